ball_motion_controller: RTL and testbench



---
 rtl/pong_pkg.sv | 40 ++++
 rtl/serve_timer.sv | 34 +++
 rtl/ball_motion_controller.sv | 178 +++++++++++++++++
 tb/tb_ball_motion_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, bounce-detector codes, screen defaults
// and the clamped single-axis position step used by the ball sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVE   = 3'd1,
    ST_MOVE    = 3'd2,
    ST_STEP    = 3'd3,
    ST_EVAL    = 3'd4,
    ST_RESOLVE = 3'd5,
    ST_OVER    = 3'd6
  } state_t;

  localparam logic [1:0] BOUNCE_NONE   = 2'd0;
  localparam logic [1:0] BOUNCE_PADDLE = 2'd1;
  localparam logic [1:0] BOUNCE_WALL   = 2'd2;
  localparam logic [1:0] BOUNCE_SCORE  = 2'd3;

  localparam int SCREEN_X_DEFAULT = 640;
  localparam int SCREEN_Y_DEFAULT = 480;

  // Move one axis by step in the given direction; the result never leaves
  // [0, limit], so an overshoot sticks at the edge instead of wrapping.
  function automatic logic [10:0] advance_axis(input logic [10:0] pos,
                                               input logic [10:0] step,
                                               input logic        dir,
                                               input logic [10:0] limit);
    logic [10:0] sum;
    logic [10:0] res;
    sum = pos + step;
    if (dir) begin
      res = (sum > limit) ? limit : sum;
    end else begin
      res = (pos < step) ? 11'd0 : (pos - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/serve_timer.sv
// serve_timer: counts frame ticks while the ball waits at centre. done is
// asserted combinationally with the tick that reaches SERVE_DELAY, and the
// count restarts from zero after it or whenever clear is high.
module serve_timer #(
  parameter int SERVE_DELAY = 60
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(SERVE_DELAY - 1);

  logic [CW-1:0] count;

  assign done = tick && !clear && (count == LAST);

  // Tick counter, restarted by clear or by the completing tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ball_motion_controller.sv
// ball_motion_controller: per-frame ball sequencer for Pong. Steps the ball,
// pulses the bounce detector, resolves its code into direction / score /
// serve / game-over updates. Optional macro BALL_SPEEDUP_EN makes paddle
// bounces speed the ball up to MAX_STEP.
module ball_motion_controller
  import pong_pkg::*;
#(
  parameter int SCREEN_X    = SCREEN_X_DEFAULT,
  parameter int SCREEN_Y    = SCREEN_Y_DEFAULT,
  parameter int BALL_SIZE   = 8,
  parameter int STEP        = 2,
  parameter int MAX_STEP    = 6,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [1:0] bounce,
  output logic       bounce_enable,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic       ball_dir_x,
  output logic       ball_dir_y,
  output logic [3:0] ball_step,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic       game_over
);

  localparam logic [10:0] MAX_X  = 11'(SCREEN_X - BALL_SIZE);
  localparam logic [10:0] MAX_Y  = 11'(SCREEN_Y - BALL_SIZE);
  localparam logic [9:0]  CX     = 10'((SCREEN_X - BALL_SIZE) / 2);
  localparam logic [9:0]  CY     = 10'((SCREEN_Y - BALL_SIZE) / 2);
  localparam logic [10:0] HALF_X = 11'(SCREEN_X / 2);
  localparam logic [3:0]  STEP_L = 4'(STEP);
  localparam logic [3:0]  WIN_L  = 4'(WIN_SCORE);

  state_t      state;
  logic        serve_done;
  logic [10:0] next_x;
  logic [10:0] next_y;
  logic        left_side;
  logic [3:0]  score_1_inc;
  logic [3:0]  score_2_inc;
  logic        win_hit;
  logic [3:0]  paddle_step;

  serve_timer #(
    .SERVE_DELAY(SERVE_DELAY)
  ) u_serve_timer (
    .clock(clock),
    .reset(reset),
    .clear(state != ST_SERVE),
    .tick (frame_tick),
    .done (serve_done)
  );

  assign next_x = advance_axis({1'b0, ball_pos_x}, {7'd0, ball_step}, ball_dir_x, MAX_X);
  assign next_y = advance_axis({1'b0, ball_pos_y}, {7'd0, ball_step}, ball_dir_y, MAX_Y);

  // A ball in the left half means the left player conceded, so the right
  // player (score_2) gains; scores stick at WIN_SCORE.
  assign left_side   = ({1'b0, ball_pos_x} < HALF_X);
  assign score_1_inc = (score_1 >= WIN_L) ? score_1 : (score_1 + 4'd1);
  assign score_2_inc = (score_2 >= WIN_L) ? score_2 : (score_2 + 4'd1);
  assign win_hit     = left_side ? (score_2_inc == WIN_L) : (score_1_inc == WIN_L);

`ifdef BALL_SPEEDUP_EN
  localparam logic [3:0] MAX_STEP_L = 4'(MAX_STEP);
  assign paddle_step = (ball_step >= MAX_STEP_L) ? MAX_STEP_L : (ball_step + 4'd1);
`else
  assign paddle_step = STEP_L;
`endif

  // Frame sequencer: state, position, direction, score and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      ball_pos_x    <= CX;
      ball_pos_y    <= CY;
      ball_dir_x    <= 1'b1;
      ball_dir_y    <= 1'b1;
      ball_step     <= STEP_L;
      score_1       <= 4'd0;
      score_2       <= 4'd0;
      bounce_enable <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      bounce_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          ball_pos_x <= CX;
          ball_pos_y <= CY;
          if (start) begin
            state      <= ST_SERVE;
            score_1    <= 4'd0;
            score_2    <= 4'd0;
            ball_dir_x <= 1'b1;
            ball_step  <= STEP_L;
          end
        end
        ST_SERVE: begin
          ball_pos_x <= CX;
          ball_pos_y <= CY;
          ball_step  <= STEP_L;
          if (serve_done) begin
            state <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (frame_tick) begin
            ball_pos_x <= next_x[9:0];
            ball_pos_y <= next_y[9:0];
            state      <= ST_STEP;
          end
        end
        ST_STEP: begin
          bounce_enable <= 1'b1;
          state         <= ST_EVAL;
        end
        ST_EVAL: begin
          state <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          case (bounce)
            BOUNCE_PADDLE: begin
              ball_dir_x <= ~ball_dir_x;
              ball_step  <= paddle_step;
              state      <= ST_MOVE;
            end
            BOUNCE_WALL: begin
              ball_dir_y <= ~ball_dir_y;
              state      <= ST_MOVE;
            end
            BOUNCE_SCORE: begin
              if (left_side) begin
                score_2 <= score_2_inc;
              end else begin
                score_1 <= score_1_inc;
              end
              ball_pos_x <= CX;
              ball_pos_y <= CY;
              if (win_hit) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
              end else begin
                state      <= ST_SERVE;
                ball_dir_x <= ~left_side;
                ball_dir_y <= ~ball_dir_y;
                ball_step  <= STEP_L;
              end
            end
            default: begin
              state <= ST_MOVE;
            end
          endcase
        end
        ST_OVER: begin
          ball_pos_x <= CX;
          ball_pos_y <= CY;
          if (start) begin
            state     <= ST_SERVE;
            score_1   <= 4'd0;
            score_2   <= 4'd0;
            game_over <= 1'b0;
            ball_step <= STEP_L;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_controller.sv
// tb_ball_motion_controller: randomized self-checking bench. A second
// instance with SCREEN_Y=482 gets an odd centre row so the low-edge clamp
// (y=1 stepping by 2) is reachable; both see identical stimulus.
module tb_ball_motion_controller;

  localparam int CX = 316, CY = 236, CY2 = 237;
  localparam int MAXX = 632, MAXY = 472, MAXY2 = 474;
  localparam int STEP = 2, MAX_STEP = 6, DELAY = 60, WIN = 9;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [1:0] bounce = 2'd0;

  logic       bounce_enable, ball_dir_x, ball_dir_y, game_over;
  logic [9:0] ball_pos_x, ball_pos_y;
  logic [3:0] ball_step, score_1, score_2;

  logic       be2, dx2, dy2, go2;
  logic [9:0] x2, y2;
  logic [3:0] step2, s1b, s2b;

  ball_motion_controller dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
    .bounce(bounce), .bounce_enable(bounce_enable),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .ball_dir_x(ball_dir_x), .ball_dir_y(ball_dir_y), .ball_step(ball_step),
    .score_1(score_1), .score_2(score_2), .game_over(game_over)
  );

  ball_motion_controller #(.SCREEN_Y(482)) dut2 (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
    .bounce(bounce), .bounce_enable(be2),
    .ball_pos_x(x2), .ball_pos_y(y2),
    .ball_dir_x(dx2), .ball_dir_y(dy2), .ball_step(step2),
    .score_1(s1b), .score_2(s2b), .game_over(go2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game-level quantities, phase 0=move 1=serve 2=over 3=idle
  int m_x, m_y, m_y2, m_step, m_s1, m_s2, m_phase;
  bit m_dx, m_dy, m_over;

  function automatic int adv(input int p, input bit d, input int s, input int lim);
    if (d) return (p + s > lim) ? lim : p + s;
    return (p - s < 0) ? 0 : p - s;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_x = CX; m_y = CY; m_y2 = CY2; m_dx = 1; m_dy = 1; m_step = STEP;
    m_s1 = 0; m_s2 = 0; m_over = 0; m_phase = 3;
  endtask

  task automatic test_reset();
    logic [44:0] got, exp;
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    model_reset();
    got = {ball_pos_x, ball_pos_y, y2, ball_dir_x, ball_dir_y, ball_step, score_1, score_2, game_over};
    exp = {10'(CX), 10'(CY), 10'(CY2), 1'b1, 1'b1, 4'(STEP), 4'd0, 4'd0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_state: got %h expected %h", got, exp); end
    n_checks++;
    if ({bounce_enable, be2} !== 2'b00) begin n_fail++; $display("FAIL reset_enable: got %b expected 00", {bounce_enable, be2}); end
    // ticks in IDLE must not move the ball
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); cyc();
      n_checks++;
      if ({ball_pos_x, ball_pos_y, bounce_enable} !== {10'(CX), 10'(CY), 1'b0}) begin
        n_fail++; $display("FAIL idle_hold: got x=%0d y=%0d en=%b expected x=%0d y=%0d en=0", ball_pos_x, ball_pos_y, bounce_enable, CX, CY);
      end
    end
  endtask

  task automatic do_start(input bit from_idle);
    start = 1'b1; cyc(); start = 1'b0;
    m_s1 = 0; m_s2 = 0; m_over = 0; m_step = STEP; m_phase = 1;
    if (from_idle) m_dx = 1;
    n_checks++;
    if ({score_1, score_2, game_over, ball_step, ball_dir_x} !== {4'd0, 4'd0, 1'b0, 4'(m_step), m_dx}) begin
      n_fail++; $display("FAIL start: got s1=%0d s2=%0d over=%b step=%0d dx=%b expected 0 0 0 %0d %b", score_1, score_2, game_over, ball_step, ball_dir_x, m_step, m_dx);
    end
  endtask

  task automatic do_serve();
    m_x = CX; m_y = CY; m_y2 = CY2;
    for (int i = 0; i <= DELAY; i++) begin
      n_checks++;
      if ({ball_pos_x, ball_pos_y, y2, bounce_enable, ball_step} !== {10'(CX), 10'(CY), 10'(CY2), 1'b0, 4'(m_step)}) begin
        n_fail++; $display("FAIL serve_hold[%0d]: got x=%0d y=%0d y2=%0d en=%b step=%0d expected %0d %0d %0d 0 %0d", i, ball_pos_x, ball_pos_y, y2, bounce_enable, ball_step, CX, CY, CY2, m_step);
      end
      if (i < DELAY) begin
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        repeat ($urandom_range(0, 3)) cyc();
      end
    end
    m_phase = 0;
  endtask

  task automatic do_frame(input int code, input bit extra_tick, input bit noise);
    logic [14:0] got, exp;
    bit won;
    frame_tick = 1'b1; cyc();             // now T+1
    frame_tick = 1'b0; start = noise;
    m_x = adv(m_x, m_dx, m_step, MAXX);
    m_y = adv(m_y, m_dy, m_step, MAXY);
    m_y2 = adv(m_y2, m_dy, m_step, MAXY2);
    n_checks++;
    if ({ball_pos_x, ball_pos_y, x2, y2} !== {10'(m_x), 10'(m_y), 10'(m_x), 10'(m_y2)}) begin
      n_fail++; $display("FAIL step_pos: got (%0d,%0d)/(%0d,%0d) expected (%0d,%0d)/(%0d,%0d)", ball_pos_x, ball_pos_y, x2, y2, m_x, m_y, m_x, m_y2);
    end
    n_checks++;
    if ({bounce_enable, be2} !== 2'b00) begin n_fail++; $display("FAIL enable_t1: got %b expected 00", {bounce_enable, be2}); end
    cyc();                                 // T+2
    frame_tick = extra_tick; bounce = 2'(code);
    n_checks++;
    if ({bounce_enable, be2} !== 2'b11) begin n_fail++; $display("FAIL enable_t2: got %b expected 11", {bounce_enable, be2}); end
    cyc();                                 // T+3
    frame_tick = 1'b0;
    n_checks++;
    if ({bounce_enable, be2} !== 2'b00) begin n_fail++; $display("FAIL enable_t3: got %b expected 00", {bounce_enable, be2}); end
    cyc();                                 // T+4
    bounce = 2'd0; start = 1'b0;
    won = 0;
    case (code)
      1: begin
        m_dx = !m_dx;
`ifdef BALL_SPEEDUP_EN
        m_step = (m_step + 1 > MAX_STEP) ? MAX_STEP : m_step + 1;
`endif
      end
      2: m_dy = !m_dy;
      3: begin
        if (m_x < 320) begin
          if (m_s2 < WIN) m_s2++;
          m_dx = 0; won = (m_s2 == WIN);
        end else begin
          if (m_s1 < WIN) m_s1++;
          m_dx = 1; won = (m_s1 == WIN);
        end
        if (won) begin m_over = 1; m_phase = 2; end
        else begin m_dy = !m_dy; m_step = STEP; m_phase = 1; end
      end
      default: ;
    endcase
    got = {ball_dir_x, ball_dir_y, ball_step, score_1, score_2, game_over};
    exp = {m_dx, m_dy, 4'(m_step), 4'(m_s1), 4'(m_s2), m_over};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL resolve(code %0d): got %h expected %h", code, got, exp); end
    n_checks++;
    if ({dx2, dy2, step2, s1b, s2b, go2} !== exp) begin n_fail++; $display("FAIL resolve2(code %0d): got %h expected %h", code, {dx2, dy2, step2, s1b, s2b, go2}, exp); end
    if (code != 3) begin
      n_checks++;
      if ({ball_pos_x, ball_pos_y, y2} !== {10'(m_x), 10'(m_y), 10'(m_y2)}) begin
        n_fail++; $display("FAIL resolve_pos: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", ball_pos_x, ball_pos_y, y2, m_x, m_y, m_y2);
      end
    end
    if (extra_tick && m_phase == 0) begin
      cyc(); cyc(); cyc();
      n_checks++;
      if ({ball_pos_x, ball_pos_y, bounce_enable} !== {10'(m_x), 10'(m_y), 1'b0}) begin
        n_fail++; $display("FAIL dropped_tick: got (%0d,%0d) en=%b expected (%0d,%0d) en=0", ball_pos_x, ball_pos_y, bounce_enable, m_x, m_y);
      end
    end
    if (code == 3) begin m_x = CX; m_y = CY; m_y2 = CY2; end
  endtask

  task automatic after_frame();
    if (m_phase == 1) do_serve();
    else if (m_phase == 2) begin do_start(1'b0); do_serve(); end
  endtask

  task automatic test_serve();
    do_start(1'b1);
    do_serve();
    do_frame(0, 0, 0);     // (316,236) -> (318,238)
  endtask

  task automatic test_codes();
    do_frame(1, 0, 1);
    do_frame(2, 0, 0);
    do_frame(1, 0, 1);
    do_frame(0, 0, 0);
    do_frame(3, 0, 0);     // x=320 is the right half: score_1
    after_frame();
  endtask

  task automatic test_dropped_tick();
    do_frame(0, 1, 0);
    do_frame(2, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int code;
      code = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      do_frame(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      after_frame();
    end
  endtask

  task automatic test_clamp();
    if (m_dy) do_frame(2, 0, 0);
    if (m_dx) do_frame(1, 0, 0);
    for (int i = 0; i < 300 && m_y2 != 0; i++) do_frame(0, 0, 0);
    do_frame(0, 0, 0);
    n_checks++;
    if ({ball_pos_y, y2} !== 20'd0) begin n_fail++; $display("FAIL clamp_low: got y=%0d y2=%0d expected 0 0", ball_pos_y, y2); end
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 40 && m_phase != 2; i++) begin
      do_frame(3, 0, 0);
      if (m_phase == 1) do_serve();
    end
    n_checks++;
    if ({score_2, game_over} !== {4'd9, 1'b1}) begin n_fail++; $display("FAIL game_end: got s2=%0d over=%b expected 9 1", score_2, game_over); end
    // OVER ignores ticks and score codes
    bounce = 2'd3;
    for (int i = 0; i < 4; i++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
    bounce = 2'd0;
    n_checks++;
    if ({score_1, score_2, game_over, ball_pos_x, ball_pos_y} !== {4'(m_s1), 4'd9, 1'b1, 10'(CX), 10'(CY)}) begin
      n_fail++; $display("FAIL over_hold: got s1=%0d s2=%0d over=%b (%0d,%0d) expected %0d 9 1 (%0d,%0d)", score_1, score_2, game_over, ball_pos_x, ball_pos_y, m_s1, CX, CY);
    end
    do_start(1'b0);
    do_serve();
  endtask

  task automatic test_speedup();
    int exp_step[5];
`ifdef BALL_SPEEDUP_EN
    exp_step = '{3, 4, 5, 6, 6};
`else
    exp_step = '{2, 2, 2, 2, 2};
`endif
    for (int i = 0; i < 5; i++) begin
      do_frame(1, 0, 0);
      n_checks++;
      if (ball_step !== 4'(exp_step[i])) begin n_fail++; $display("FAIL paddle_step[%0d]: got %0d expected %0d", i, ball_step, exp_step[i]); end
    end
    do_frame(3, 0, 0);
    after_frame();
    n_checks++;
    if (ball_step !== 4'd2) begin n_fail++; $display("FAIL step_reload: got %0d expected 2", ball_step); end
  endtask

  task automatic test_reset_mid();
    logic [44:0] got, exp;
    do_frame(3, 0, 0);        // leave a non-zero score behind
    after_frame();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;   // T+1
    cyc(); bounce = 2'd3;                           // T+2
    cyc(); reset = 1'b1;                            // T+3 (RESOLVE)
    cyc(); reset = 1'b0; bounce = 2'd0;             // T+4
    model_reset();
    got = {ball_pos_x, ball_pos_y, y2, ball_dir_x, ball_dir_y, ball_step, score_1, score_2, game_over};
    exp = {10'(CX), 10'(CY), 10'(CY2), 1'b1, 1'b1, 4'(STEP), 4'd0, 4'd0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_mid: got %h expected %h", got, exp); end
    n_checks++;
    if (bounce_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mid_enable: got %b expected 0", bounce_enable); end
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    n_checks++;
    if ({ball_pos_x, ball_pos_y} !== {10'(CX), 10'(CY)}) begin n_fail++; $display("FAIL reset_mid_idle: got (%0d,%0d) expected (%0d,%0d)", ball_pos_x, ball_pos_y, CX, CY); end
    do_start(1'b1);
    do_serve();
    do_frame(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_codes();
    test_dropped_tick();
    test_random();
    test_clamp();
    test_game_over();
    test_speedup();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
